// File: rtl/trace_pkg.sv
// trace_pkg: state encoding and pointer-width helper shared by the trace buffer
package trace_pkg;
  typedef enum logic [1:0] {
    TR_IDLE  = 2'd0,
    TR_ARMED = 2'd1,
    TR_POST  = 2'd2,
    TR_DONE  = 2'd3
  } tr_state_t;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port RAM, registered read returning old data on collision
module trace_ram import trace_pkg::*; #(
  parameter int W = 128,
  parameter int DEPTH = 64,
  localparam int AW = ptr_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rstb,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge i_clk)
    if (i_we) mem[i_waddr] <= i_wdata;
  always_ff @(posedge i_clk)
    if (!i_rstb) o_rdata <= '0;
    else if (i_re) o_rdata <= mem[i_raddr];
endmodule

// File: rtl/trace_capture.sv
// trace_capture: triggered circular trace buffer with oldest-first readback
module trace_capture import trace_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH = 64,
  parameter int POST_TRIG = 32,
  localparam int SW = CHANNELS * DATA_W,
  localparam int AW = ptr_w(DEPTH),
  localparam int CW = AW + 1,
  localparam int TW = ptr_w(CHANNELS)
) (
  input  logic              i_clk,
  input  logic              i_rstb,
  input  logic              i_clk_en,
  input  logic [SW-1:0]     i_probe,
  input  logic              i_probe_valid,
  input  logic              i_arm,
  input  logic [TW-1:0]     i_trig_chan,
  input  logic [DATA_W-1:0] i_trig_mask,
  input  logic [DATA_W-1:0] i_trig_value,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [SW-1:0]     o_rd_data,
  output logic              o_rd_valid,
  output logic [1:0]        o_state,
  output logic [CW-1:0]     o_count,
  output logic [AW-1:0]     o_trig_idx
);
  localparam logic [AW-1:0] LIM = AW'(DEPTH - 1 - POST_TRIG);
  tr_state_t state, state_n;
  logic [AW-1:0] wr_ptr, post_cnt, pre, rd_phys;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] sel;
  logic wrapped, wr_en, clr, trig, hit, match;
  always_comb begin
    sel = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (i_trig_chan == TW'(k)) sel = i_probe[k*DATA_W +: DATA_W];
  end
  assign hit = i_clk_en & i_probe_valid;
  assign match = ((sel ^ i_trig_value) & i_trig_mask) == '0;
  always_comb begin
    state_n = state;
    wr_en = 1'b0;
    clr = 1'b0;
    trig = 1'b0;
    if (i_clk_en) begin
      if (i_arm) begin
        state_n = TR_ARMED;
        clr = 1'b1;
      end else if (hit && (state == TR_ARMED || state == TR_POST)) begin
        wr_en = 1'b1;
        if (state == TR_ARMED && match) begin
          trig = 1'b1;
          state_n = (POST_TRIG == 0) ? TR_DONE : TR_POST;
        end else if (state == TR_POST && post_cnt == AW'(POST_TRIG - 1)) begin
          state_n = TR_DONE;
        end
      end
    end
  end
  always_ff @(posedge i_clk)
    if (!i_rstb) begin
      state <= TR_IDLE;
      wr_ptr <= '0;
      count <= '0;
      post_cnt <= '0;
      wrapped <= 1'b0;
      pre <= '0;
      o_rd_valid <= 1'b0;
    end else if (i_clk_en) begin
      state <= state_n;
      o_rd_valid <= i_rd_en;
      if (clr) begin
        wr_ptr <= '0;
        count <= '0;
        post_cnt <= '0;
        wrapped <= 1'b0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        wrapped <= wrapped | (&wr_ptr);
        count <= count + CW'(count != CW'(DEPTH));
        post_cnt <= post_cnt + AW'(state == TR_POST);
        if (trig) pre <= (count == CW'(DEPTH)) ? '1 : count[AW-1:0];
      end
    end
  // once wrapped, the write pointer marks the oldest entry
  assign rd_phys = (wrapped ? wr_ptr : '0) + i_rd_addr;
  assign o_trig_idx = (pre < LIM) ? pre : LIM;
  assign o_state = state;
  assign o_count = count;
  trace_ram #(.W(SW), .DEPTH(DEPTH)) u_ram (
    .i_clk(i_clk),
    .i_rstb(i_rstb),
    .i_we(wr_en),
    .i_waddr(wr_ptr),
    .i_wdata(i_probe),
    .i_re(i_clk_en & i_rd_en),
    .i_raddr(rd_phys),
    .o_rdata(o_rd_data)
  );
endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: randomized and directed bench against a sample-history model
module tb_trace_capture;
  localparam int DW = 32, DEPTH = 64, PT = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstb, clk_en, probe_valid, arm, rd_en;
  logic [127:0] probe;
  logic [1:0] trig_chan;
  logic [31:0] mask, value;
  logic [5:0] rd_addr;
  logic [127:0] rd_data, rd_data0;
  logic rd_valid, rd_valid0;
  logic [1:0] state, state0;
  logic [6:0] count;
  logic [3:0] count0;
  logic [5:0] trig_idx;
  logic [2:0] trig_idx0;
  int checks = 0, errors = 0;
  int mst, nst, tpos, npost;
  logic [127:0] q[$];
  logic mvalid, mknown;
  logic [127:0] mdata;

  trace_capture #(.DATA_W(32), .CHANNELS(4), .DEPTH(DEPTH), .POST_TRIG(PT)) dut (
    .i_clk(clk), .i_rstb(rstb), .i_clk_en(clk_en), .i_probe(probe), .i_probe_valid(probe_valid),
    .i_arm(arm), .i_trig_chan(trig_chan), .i_trig_mask(mask), .i_trig_value(value),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_state(state), .o_count(count), .o_trig_idx(trig_idx));

  trace_capture #(.DATA_W(32), .CHANNELS(4), .DEPTH(8), .POST_TRIG(0)) dut0 (
    .i_clk(clk), .i_rstb(rstb), .i_clk_en(clk_en), .i_probe(probe), .i_probe_valid(probe_valid),
    .i_arm(arm), .i_trig_chan(trig_chan), .i_trig_mask(mask), .i_trig_value(value),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr[2:0]), .o_rd_data(rd_data0), .o_rd_valid(rd_valid0),
    .o_state(state0), .o_count(count0), .o_trig_idx(trig_idx0));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // q holds the newest DEPTH stored samples since the last arm, oldest first
  task automatic model_step();
    if (!rstb) begin
      mst = 0; q.delete(); nst = 0; tpos = -1; npost = 0;
      mvalid = 1'b0; mknown = 1'b1; mdata = '0;
    end else if (clk_en) begin
      mvalid = rd_en;
      if (rd_en) begin
        mknown = int'(rd_addr) < q.size();
        if (mknown) mdata = q[rd_addr];
      end
      if (arm) begin
        mst = 1; q.delete(); nst = 0; npost = 0;
      end else if (probe_valid && (mst == 1 || mst == 2)) begin
        q.push_back(probe);
        nst++;
        if (q.size() > DEPTH) void'(q.pop_front());
        if (mst == 1 && ((probe[trig_chan*DW +: DW] ^ value) & mask) == 0) begin
          tpos = nst - 1;
          mst = (PT == 0) ? 3 : 2;
        end else if (mst == 2) begin
          npost++;
          if (npost == PT) mst = 3;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("state", state, mst);
    check("count", count, q.size());
    check("rd_valid", rd_valid, mvalid);
    if (mknown) check("rd_data", rd_data, mdata);
    if (mst == 3) check("trig_idx", trig_idx, tpos - (nst - q.size()));
  endtask

  task automatic capture(input logic [31:0] tv, input bit gaps);
    int seq = 0;
    int n = 0;
    clk_en = 1; probe_valid = 0; rd_en = 0; trig_chan = 0; mask = '1; value = tv; arm = 1;
    tick();
    arm = 0;
    while (state != 2'd3 && n < 2000) begin
      clk_en = gaps ? 1'($urandom_range(1)) : 1'b1;
      probe_valid = gaps ? 1'($urandom_range(1)) : 1'b1;
      probe = {$urandom, $urandom, $urandom, 32'(seq)};
      tick();
      if (clk_en && probe_valid) seq++;
      n++;
    end
    check("done_wait", state, 3);
    clk_en = 1; probe_valid = 0;
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string tag);
    rd_en = 1; rd_addr = 6'(a);
    tick();
    rd_en = 0;
    check(tag, rd_data[31:0], exp);
  endtask

  initial begin
    rstb = 0; clk_en = 1; probe = '0; probe_valid = 0; arm = 0; trig_chan = 0;
    mask = 0; value = 0; rd_en = 0; rd_addr = 0;
    for (int i = 0; i < 3; i++) begin
      clk_en = 1'($urandom); probe = {$urandom, $urandom, $urandom, $urandom};
      probe_valid = 1'($urandom); arm = 1'($urandom); rd_en = 1'($urandom); rd_addr = 6'($urandom);
      tick();
    end
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_trig", trig_idx, 0);
    check("rst_state0", state0, 0);
    rstb = 1; arm = 0; rd_en = 0;

    capture(32'h10, 0);
    check("basic_count", count, 49);
    check("basic_trig", trig_idx, 16);
    rd(16, 32'h10, "basic_rd16");
    rd(0, 32'h0, "basic_rd0");

    capture(32'h100, 0);
    check("wrap_count", count, 64);
    check("wrap_trig", trig_idx, 31);
    rd(0, 32'hE1, "wrap_rd0");
    rd(31, 32'h100, "wrap_rd31");
    rd(63, 32'h120, "wrap_rd63");

    capture(32'h50, 1);
    check("gap_count", count, 64);
    check("gap_trig", trig_idx, 31);
    for (int i = 0; i < 64; i++) rd(i, 32'h31 + 32'(i), "gap_seq");

    rstb = 0; tick(); rstb = 1;
    mask = 0; arm = 1; probe_valid = 0; tick();
    arm = 0; probe_valid = 1; probe = {$urandom, $urandom, $urandom, $urandom}; tick();
    check("pt0_state", state0, 3);
    check("pt0_count", count0, 1);
    check("pt0_trig", trig_idx0, 0);
    tick();
    check("pt0_frozen", count0, 1);
    check("post_state", state, 2);

    for (int i = 0; i < 3; i++) tick();
    arm = 1; tick(); arm = 0;
    check("rearm_state", state, 1);
    check("rearm_count", count, 0);
    tick(); tick();
    check("post_again", state, 2);
    rstb = 0; tick(); rstb = 1;
    check("rst_post_state", state, 0);
    for (int i = 0; i < 4; i++) tick();
    check("idle_nowrite", count, 0);

    for (int i = 0; i < 4000; i++) begin
      rstb = $urandom_range(299) != 0;
      clk_en = $urandom_range(3) != 0;
      probe_valid = 1'($urandom);
      probe = {$urandom, $urandom, $urandom, $urandom};
      arm = $urandom_range(79) == 0;
      trig_chan = 2'($urandom);
      mask = ($urandom_range(7) == 0) ? 32'h0 : ($urandom & 32'h7);
      value = $urandom;
      rd_en = 1'($urandom);
      rd_addr = 6'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
